// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared widths, funct3 encodings, FSM states and special-case results
package muldiv_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_AW   = 5;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Architectural results for divide-by-zero and the single signed overflow case.
  localparam logic [DEF_XLEN-1:0] DIVZ_QUO = {DEF_XLEN{1'b1}};
  localparam logic [DEF_XLEN-1:0] OVF_QUO  = {1'b1, {(DEF_XLEN-1){1'b0}}};
  localparam logic [DEF_XLEN-1:0] OVF_REM  = '0;

endpackage

// File: rtl/muldiv_unit_iter_divider.sv
// rtl/muldiv_unit_iter_divider.sv - restoring divider, one quotient bit per step on unsigned magnitudes
module iter_divider
  import muldiv_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] dvsr;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // Dividend bits shift out of the quotient register's top as quotient bits shift in.
  assign shifted = {remainder, quotient[XLEN-1]};
  assign diff    = shifted - {1'b0, dvsr};

  always_ff @(posedge clk) begin
    if (reset) begin
      quotient  <= '0;
      remainder <= '0;
      dvsr      <= '0;
    end else if (load) begin
      quotient  <= dividend;
      remainder <= '0;
      dvsr      <= divisor;
    end else if (step) begin
      if (!diff[XLEN]) begin
        remainder <= diff[XLEN-1:0];
        quotient  <= {quotient[XLEN-2:0], 1'b1};
      end else begin
        remainder <= shifted[XLEN-1:0];
        quotient  <= {quotient[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with register-file-shaped write port
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int AW   = DEF_AW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [AW-1:0]   rd_addr,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            rg_wrt_en,
  output logic [AW-1:0]   rg_wrt_addr,
  output logic [XLEN-1:0] rg_wrt_data
);

  localparam int CW = $clog2(XLEN);

  state_t state, nxt;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic [AW-1:0]     rd_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   mcand;
  logic [2*XLEN-1:0] prod;
  logic              neg_p, neg_r, div_zero, ovf;

  logic              accept;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     psum;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo, rem, q_fix, r_fix, result;

  assign accept = (state == S_IDLE) && !busy && start && !flush;

  always_comb begin
    a_signed = op[2] ? !op[0] : (op != OP_MULHU);
    b_signed = op[2] ? !op[0] : !op[1];
    a_neg    = a_signed && rs1_data[XLEN-1];
    b_neg    = b_signed && rs2_data[XLEN-1];
    a_mag    = a_neg ? -rs1_data : rs1_data;
    b_mag    = b_neg ? -rs2_data : rs2_data;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (accept) nxt = S_CALC;
      S_CALC: begin
        if (flush)                      nxt = S_IDLE;
        else if (cnt == CW'(XLEN - 1))  nxt = S_DONE;
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Shift-add: the multiplier occupies the low half of prod and is consumed LSB first.
  assign psum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      op_q     <= OP_MUL;
      rd_q     <= '0;
      a_q      <= '0;
      mcand    <= '0;
      prod     <= '0;
      neg_p    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
    end else if (accept) begin
      cnt      <= '0;
      op_q     <= op;
      rd_q     <= rd_addr;
      a_q      <= rs1_data;
      mcand    <= a_mag;
      prod     <= {{XLEN{1'b0}}, b_mag};
      neg_p    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
      div_zero <= (rs2_data == '0);
      ovf      <= !op[0] && (rs1_data == OVF_QUO) && (rs2_data == '1);
    end else if (state == S_CALC) begin
      cnt  <= cnt + 1'b1;
      prod <= {psum, prod[XLEN-1:1]};
    end
  end

  iter_divider #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .step      (state == S_CALC),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quo),
    .remainder (rem)
  );

  always_comb begin
    prod_fix = neg_p ? -prod : prod;
    q_fix    = neg_p ? -quo : quo;
    r_fix    = neg_r ? -rem : rem;
    result   = '0;
    unique case (op_q)
      OP_MUL:                       result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU: begin
        if (div_zero) result = DIVZ_QUO;
        else if (ovf) result = OVF_QUO;
        else          result = q_fix;
      end
      OP_REM, OP_REMU: begin
        if (div_zero) result = a_q;
        else if (ovf) result = OVF_REM;
        else          result = r_fix;
      end
      default: result = '0;
    endcase
  end

  // Outputs are registered off the fix-up cycle, so done lands one edge after DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      rg_wrt_en   <= 1'b0;
      rg_wrt_addr <= '0;
      rg_wrt_data <= '0;
    end else begin
      done      <= 1'b0;
      rg_wrt_en <= 1'b0;
      if (state == S_DONE && !flush) begin
        done        <= 1'b1;
        rg_wrt_en   <= (rd_q != '0);
        rg_wrt_addr <= rd_q;
        rg_wrt_data <= result;
      end
      if (done || (flush && state != S_IDLE)) busy <= 1'b0;
      if (accept) busy <= 1'b1;
    end
  end

endmodule
